alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Two-port arbiter/sequencer that shares the single execute-stage ALU between requesters.
//  Port 0 is the pipeline EXE stage; port 1 is an auxiliary requester (e.g. multi-cycle or debug unit).
//  - Registers the granted operands and drives the ALU.
//  - Captures the ALU result and {N,Z,C,V}, then returns them on a valid/ready response channel.
//  - Owns the architectural status register, which supplies the ALU carry-in.
// PARAMETERS
//  DW        32  operand/result width
//  CMD_W     4   ALU command width (exe_cmd encoding)
//  PRIO_INIT 0   requester holding priority after reset
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        synchronous reset, active-low
//  req_valid  in   2        per-requester request valid
//  req_ready  out  2        per-requester request accepted (one-hot or zero)
//  req_a      in   2*DW     operand A, requester i at [i*DW +: DW]
//  req_b      in   2*DW     operand B (shifter output), same packing
//  req_cmd    in   2*CMD_W  ALU command, same packing
//  req_s      in   2        1 = update status register with this op's flags
//  alu_a      out  DW       to ALU first operand
//  alu_b      out  DW       to ALU second operand
//  alu_cmd    out  CMD_W    to ALU command
//  alu_cin    out  1        to ALU carry-in = sr_q[1]
//  alu_res    in   DW       ALU result
//  alu_sr     in   4        ALU flags {N,Z,C,V}
//  rsp_valid  out  2        per-requester response valid (one-hot or zero)
//  rsp_ready  in   2        per-requester response accept
//  rsp_res    out  DW       captured result
//  rsp_sr     out  4        captured flags {N,Z,C,V}
//  sr_q       out  4        architectural status register {N,Z,C,V}
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=IDLE, prio=PRIO_INIT, sr_q=0, rsp_res=0, rsp_sr=0,
//    alu_a/alu_b/alu_cmd=0. Any in-flight op is dropped with no response and no sr_q update.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE. Throughput is 1 op per 3 cycles minimum.
//  IDLE:
//    - Grant g = prio if req_valid[prio], else the other port if its valid is set.
//    - req_ready[g]=1 combinationally in IDLE only; 0 in all other states.
//    - On a grant, latch req_a/b/cmd/s[g] into alu_a/alu_b/alu_cmd/s_q, store g, go to ISSUE.
//    - Neither valid: stay in IDLE.
//  ISSUE:
//    - ALU operands are stable for the whole cycle.
//    - At the edge, capture rsp_res<=alu_res and rsp_sr<=alu_sr, go to RESP.
//    - If s_q=1, update sr_q: N,Z always from alu_sr.
//    - C,V from alu_sr only when cmd is 0010..0101 (ADD/ADC/SUB/SBC); otherwise C,V retain their old value.
//  RESP:
//    - rsp_valid[g]=1; rsp_res and rsp_sr are held stable.
//    - On rsp_ready[g]=1: go to IDLE, prio <= ~g.
//    - Otherwise stall; no new grant is made.
//  alu_a/b/cmd hold their last latched values outside ISSUE (no X, no glitches).
//  alu_cin reflects sr_q at ISSUE, i.e. flags from the previous completed S-op.
//  Simultaneous requests: prio holder wins; the loser wins the next arbitration (round-robin).
//  Single requester: granted regardless of prio; prio still toggles to ~g.
//  Requester contract: req_* held stable while req_valid=1 and req_ready=0.
//  rsp_ready on the non-granted port is ignored.
//  Width rules: no arithmetic in this block; flags are taken verbatim from the ALU.
// TESTING
//  1. rst=0 for 2 cycles -> all outputs 0, req_ready=00, rsp_valid=00.
//  2. Port0 ADD (0010) 5+7, s=1, rsp_ready=1 ->
//     req_ready=01 in cycle0, rsp_valid=01 in cycle2, rsp_res=12, sr_q=0000.
//  3. Both valid, prio=0: port0 MOV(0001) b=0, port1 ORR(0111) 0xF0|0x0F ->
//     port0 served first, then port1. sr_q after port0 S-op: Z=1.
//  4. Port0 SUB 0x80000000-1, s=1 -> rsp_res=0x7FFFFFFF, V=1 in sr_q.
//     Then ADC 1+1 -> alu_cin=sr_q[1] and result includes the carry.
//  5. AND with s=1 after a C=1 op -> N,Z updated, C,V unchanged.
//     Op with s=0 -> sr_q unchanged.
//  6. rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_res stable, no new grant.
//     rst=0 in ISSUE -> IDLE next cycle, no response, sr_q=0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_share_ctrl : two-port arbiter/sequencer sharing one execute ALU       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alu_share_ctrl #(
  parameter int DW        = 32,
  parameter int CMD_W     = 4,
  parameter int PRIO_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DW-1:0]      req_a,
  input  logic [2*DW-1:0]      req_b,
  input  logic [2*CMD_W-1:0]   req_cmd,
  input  logic [1:0]           req_s,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [CMD_W-1:0]     alu_cmd,
  output logic                 alu_cin,
  input  logic [DW-1:0]        alu_res,
  input  logic [3:0]           alu_sr,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DW-1:0]        rsp_res,
  output logic [3:0]           rsp_sr,
  output logic [3:0]           sr_q
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Commands whose carry/overflow outputs are architecturally meaningful.
  localparam logic [CMD_W-1:0] CMD_CV_LO = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_CV_HI = CMD_W'(5);

  localparam logic PRIO_RST = 1'(PRIO_INIT);

  logic [1:0]       state_q;
  logic             prio_q;
  logic             gnt_q;
  logic             s_q;

  logic             grant_any;
  logic             grant_sel;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  logic [CMD_W-1:0] sel_cmd;
  logic             sel_s;
  logic             cv_update;
  logic             rsp_fire;

  always_comb begin
    grant_any = 1'b0;
    grant_sel = prio_q;
    if (req_valid[prio_q]) begin
      grant_any = 1'b1;
      grant_sel = prio_q;
    end else if (req_valid[~prio_q]) begin
      grant_any = 1'b1;
      grant_sel = ~prio_q;
    end
  end

  assign sel_a   = grant_sel ? req_a[DW +: DW]          : req_a[0 +: DW];
  assign sel_b   = grant_sel ? req_b[DW +: DW]          : req_b[0 +: DW];
  assign sel_cmd = grant_sel ? req_cmd[CMD_W +: CMD_W]  : req_cmd[0 +: CMD_W];
  assign sel_s   = grant_sel ? req_s[1]                 : req_s[0];

  assign req_ready = (state_q == ST_IDLE && grant_any) ? {grant_sel, ~grant_sel} : 2'b00;
  assign rsp_valid = (state_q == ST_RESP) ? {gnt_q, ~gnt_q} : 2'b00;
  assign rsp_fire  = (state_q == ST_RESP) && rsp_ready[gnt_q];

  assign cv_update = (alu_cmd >= CMD_CV_LO) && (alu_cmd <= CMD_CV_HI);
  assign alu_cin   = sr_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      prio_q  <= PRIO_RST;
      gnt_q   <= 1'b0;
      s_q     <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
      rsp_res <= '0;
      rsp_sr  <= '0;
      sr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_cmd <= sel_cmd;
            s_q     <= sel_s;
            gnt_q   <= grant_sel;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_res <= alu_res;
          rsp_sr  <= alu_sr;
          if (s_q) begin
            sr_q[3:2] <= alu_sr[3:2];
            if (cv_update) begin
              sr_q[1:0] <= alu_sr[1:0];
            end
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          // The served port yields priority so the other side wins next time.
          if (rsp_fire) begin
            prio_q  <= ~gnt_q;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
